// File: rtl/rd_pkg.sv
// Shared types and helpers for the streaming read controller and its output FIFO.
package rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FIN   = 2'd3
    } rd_state_t;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int clog2_int(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rd_sync_fifo.sv
// First-word-fall-through FIFO: the head entry sits in its own register so dout/valid
// come straight from flops; the remaining DEPTH-1 entries live in a circular buffer.
module rd_sync_fifo import rd_pkg::*; #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [clog2_int(DEPTH):0] free_count
);

    localparam int CW        = clog2_int(DEPTH) + 1;
    localparam int MEM_DEPTH = DEPTH - 1;
    localparam int PW        = (MEM_DEPTH > 1) ? clog2_int(MEM_DEPTH) : 1;

    logic [WIDTH-1:0] mem [MEM_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    mem_count;
    logic             head_valid;
    logic [WIDTH-1:0] head_data;

    logic head_load;
    logic from_mem;
    logic bypass;
    logic mem_write;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(MEM_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // The head refills whenever it is empty or being consumed; an empty buffer lets a
    // pushed word bypass straight into the head register.
    assign head_load = !head_valid || pop;
    assign from_mem  = head_load && (mem_count != '0);
    assign bypass    = head_load && (mem_count == '0) && push;
    assign mem_write = push && !bypass;

    assign dout       = head_data;
    assign empty      = !head_valid;
    assign free_count = CW'(DEPTH) - mem_count - CW'(head_valid);
    assign full       = (free_count == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_valid <= 1'b0;
            head_data  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
        end else begin
            if (head_load) begin
                if (from_mem) begin
                    head_data  <= mem[rd_ptr];
                    head_valid <= 1'b1;
                    rd_ptr     <= next_ptr(rd_ptr);
                end else if (push) begin
                    head_data  <= din;
                    head_valid <= 1'b1;
                end else begin
                    head_valid <= 1'b0;
                end
            end
            if (mem_write) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (mem_write && !from_mem) begin
                mem_count <= mem_count + CW'(1);
            end else if (!mem_write && from_mem) begin
                mem_count <= mem_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/rd_stream_ctrl.sv
// Turns an (address, count) command into single-word engine reads at consecutive
// addresses and streams the returned words out through a FIFO with a last flag.
module rd_stream_ctrl import rd_pkg::*; #(
    parameter int ADDR_WIDTH  = 33,
    parameter int DATA_WIDTH  = 256,
    parameter int COUNT_WIDTH = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int CYC_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [COUNT_WIDTH-1:0] cmd_count,
    output logic                   eng_start,
    output logic [ADDR_WIDTH-1:0]  eng_addr,
    input  logic [DATA_WIDTH-1:0]  eng_data,
    input  logic                   eng_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   cmd_done,
    output logic [CYC_WIDTH-1:0]   cycle_count
);

    localparam int FCW = clog2_int(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(bytes_per_word(DATA_WIDTH));

    rd_state_t state;
    rd_state_t next_state;

    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   accept;
    logic                   can_issue;
    logic                   fifo_push;
    logic                   word_last;
    logic [FCW-1:0]         fifo_free;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_WIDTH:0]    fifo_dout;

    // Commands and stream words both use valid/ready: a transfer happens on the rising
    // clk edge where valid and ready are both high; valid side holds its payload until then.
    assign accept    = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign can_issue = (fifo_free != '0);
    assign fifo_push = (state == ST_WAIT) && eng_done;
    assign word_last = (remaining == COUNT_WIDTH'(1));
    assign eng_addr  = cur_addr;

    always_comb begin
        next_state = state;
        eng_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = (cmd_count != '0) ? ST_ISSUE : ST_FIN;
                end
            end
            ST_ISSUE: begin
                // A free slot is reserved before issuing, so the single outstanding
                // read always has room when it returns.
                if (can_issue) begin
                    eng_start  = 1'b1;
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (eng_done) begin
                    next_state = word_last ? ST_FIN : ST_ISSUE;
                end
            end
            ST_FIN: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b0;
            cur_addr    <= '0;
            remaining   <= '0;
            busy        <= 1'b0;
            cmd_done    <= 1'b0;
            cycle_count <= '0;
        end else begin
            state     <= next_state;
            cmd_ready <= (next_state == ST_IDLE);
            cmd_done  <= (state == ST_FIN);
            if (accept) begin
                cur_addr    <= cmd_addr;
                remaining   <= cmd_count;
                cycle_count <= '0;
                busy        <= 1'b1;
            end else begin
                if (busy && (cycle_count != '1)) begin
                    cycle_count <= cycle_count + CYC_WIDTH'(1);
                end
                if (fifo_push) begin
                    remaining <= remaining - COUNT_WIDTH'(1);
                    cur_addr  <= cur_addr + STRIDE;
                end
                if (state == ST_FIN) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    rd_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (fifo_push),
        .din        ({word_last, eng_data}),
        .pop        (out_ready),
        .dout       (fifo_dout),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .free_count (fifo_free)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_dout[DATA_WIDTH-1:0];
    assign out_last  = fifo_dout[DATA_WIDTH];

    no_push_when_full: assert property (@(posedge clk) disable iff (!resetn)
        !(fifo_push && fifo_full));

endmodule

// File: tb/tb_rd_stream_ctrl.sv
// Bench for rd_stream_ctrl: an engine model answers reads, a scoreboard checks the
// stream, command completion and cycle counts against queues filled at command time.
module tb_rd_stream_ctrl;

    localparam int AW    = 33;
    localparam int DW    = 256;
    localparam int CNTW  = 16;
    localparam int FD    = 8;
    localparam int CYW   = 32;
    localparam int BYTES = DW / 8;

    typedef struct {
        int ta;
        int exp_cc;
    } cmd_rec_t;

    logic            clk = 1'b0;
    logic            resetn;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_addr;
    logic [CNTW-1:0] cmd_count;
    logic            eng_start;
    logic [AW-1:0]   eng_addr;
    logic [DW-1:0]   eng_data;
    logic            eng_done;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            busy;
    logic            cmd_done;
    logic [CYW-1:0]  cycle_count;

    logic [DW:0] exp_q[$];
    logic [AW:0] exp_addr_q[$];
    cmd_rec_t    exp_cmd_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int lat_min    = 1;
    int lat_max    = 1;
    int ready_mode = 1;
    bit data_a5    = 1'b0;
    int eng_cnt    = 0;
    int n_starts   = 0;
    bit squash     = 1'b0;
    bit spur_req   = 1'b0;

    rd_stream_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .COUNT_WIDTH (CNTW),
        .FIFO_DEPTH  (FD),
        .CYC_WIDTH   (CYW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_count   (cmd_count),
        .eng_start   (eng_start),
        .eng_addr    (eng_addr),
        .eng_data    (eng_data),
        .eng_done    (eng_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .cmd_done    (cmd_done),
        .cycle_count (cycle_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [263:0] act, input logic [263:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] base, input int i);
        longint s;
        longint m;
        s = longint'(base) + longint'(i) * BYTES;
        m = longint'(1) << AW;
        return AW'(s % m);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_eng_start"}, eng_start, 0);
        check({tag, "_eng_addr"}, eng_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cmd_done"}, cmd_done, 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [AW-1:0] addr, input int count, input int exp_cc);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_count = CNTW'(count);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("cmd_accept", ok, 1);
        if (ok) begin
            for (int i = 0; i < count; i++) begin
                exp_addr_q.push_back({(i == count - 1), word_addr(addr, i)});
            end
            exp_cmd_q.push_back('{cyc + 1, exp_cc});
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp_cmd_q.size() == 0 && exp_addr_q.size() == 0 &&
                eng_cnt == 0 && cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", ok, 1);
    endtask

    // ---------------- consumer ready ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        end
    end

    // ---------------- engine model ----------------
    initial begin
        logic [AW:0]   e;
        logic [AW-1:0] pend_addr;
        logic          pend_last;
        logic [DW-1:0] pend_data;
        logic          prev_start;
        pend_addr  = '0;
        pend_last  = 1'b0;
        pend_data  = '0;
        prev_start = 1'b0;
        eng_done   = 1'b0;
        eng_data   = '0;
        forever begin
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (eng_start) begin
                n_starts++;
                check("start_while_outstanding", (eng_cnt != 0), 0);
                check("start_back_to_back", prev_start, 0);
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    e = exp_addr_q.pop_front();
                    check("eng_addr", eng_addr, e[AW-1:0]);
                    pend_addr = e[AW-1:0];
                    pend_last = e[AW];
                end
                if (data_a5) begin
                    pend_data = {BYTES{8'hA5}};
                end else begin
                    for (int i = 0; i < DW / 32; i++) begin
                        pend_data[i*32 +: 32] = $urandom();
                    end
                end
                eng_cnt = $urandom_range(lat_min, lat_max);
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done = 1'b1;
                    eng_data = pend_data;
                    if (squash) begin
                        squash = 1'b0;
                    end else begin
                        check("eng_addr_hold", eng_addr, pend_addr);
                        exp_q.push_back({pend_last, pend_data});
                    end
                end
            end else if (spur_req) begin
                spur_req = 1'b0;
                eng_data = {BYTES{8'h5A}};
                eng_done = 1'b1;
            end
            prev_start = eng_start;
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic          prev_stall;
        logic          prev_done;
        logic [DW:0]   prev_word;
        cmd_rec_t      r;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("out_hold", {out_valid, out_last, out_data}, {1'b1, prev_word});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    check("out_word", {out_last, out_data}, exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
            if (cmd_done) begin
                check("cmd_done_back_to_back", prev_done, 0);
                check("busy_at_done", busy, 0);
                if (exp_cmd_q.size() == 0) begin
                    check("unexpected_cmd_done", 1, 0);
                end else begin
                    r = exp_cmd_q.pop_front();
                    check("cycle_count_span", cycle_count, cyc - r.ta);
                    if (r.exp_cc >= 0) begin
                        check("cycle_count", cycle_count, r.exp_cc);
                    end
                end
            end
            prev_done = cmd_done;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int s0;
        bit seen;
        logic [AW-1:0] a;
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_count = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        #2;
        resetn = 1'b1;

        // single read, 0xA5 pattern, done arrives 11 cycles after the start cycle
        ready_mode = 1;
        lat_min = 11;
        lat_max = 11;
        data_a5 = 1'b1;
        s0 = n_starts;
        send_cmd(33'h100, 1, 13);
        wait_idle(500);
        check("single_starts", n_starts - s0, 1);
        data_a5 = 1'b0;

        // burst of 4 from 0: ISSUE + 3 WAIT cycles per word, plus FIN
        lat_min = 3;
        lat_max = 3;
        s0 = n_starts;
        send_cmd(33'h0, 4, 4 * (3 + 1) + 1);
        wait_idle(500);
        check("burst_starts", n_starts - s0, 4);

        // backpressure: consumer stalled, only FD reads may be issued
        ready_mode = 0;
        lat_min = 2;
        lat_max = 2;
        s0 = n_starts;
        send_cmd(33'h1000, 12, -1);
        repeat (200) @(posedge clk);
        #1;
        check("bp_stall_starts", n_starts - s0, FD);
        check("bp_stall_busy", busy, 1);
        check("bp_stall_out_valid", out_valid, 1);
        ready_mode = 1;
        wait_idle(1000);
        check("bp_total_starts", n_starts - s0, 12);

        // address wrap at 2^33
        s0 = n_starts;
        send_cmd(33'h1_FFFF_FFE0, 2, 2 * (2 + 1) + 1);
        wait_idle(500);
        check("wrap_starts", n_starts - s0, 2);

        // stray eng_done while idle, then a zero-length command
        spur_req = 1'b1;
        repeat (4) @(posedge clk);
        s0 = n_starts;
        send_cmd(33'h200, 0, 1);
        wait_idle(200);
        check("zero_starts", n_starts - s0, 0);

        // reset during the wait for word 3 of 5
        lat_min = 6;
        lat_max = 6;
        s0 = n_starts;
        send_cmd(33'h400, 5, -1);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (n_starts >= s0 + 3) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_third_start_seen", seen, 1);
        repeat (2) @(negedge clk);
        #2;
        squash = (eng_cnt > 0);
        exp_q.delete();
        exp_addr_q.delete();
        exp_cmd_q.delete();
        resetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        #2;
        resetn = 1'b1;
        repeat (12) @(posedge clk);
        s0 = n_starts;
        send_cmd(33'h40, 3, 3 * (6 + 1) + 1);
        wait_idle(500);
        check("post_rst_starts", n_starts - s0, 3);

        // randomized back-to-back commands with random consumer stalls
        ready_mode = 2;
        for (int n = 0; n < 24; n++) begin
            lat_min = 1;
            lat_max = $urandom_range(1, 6);
            a = {1'($urandom_range(0, 1)), 32'($urandom())};
            a[4:0] = 5'd0;
            send_cmd(a, $urandom_range(0, 14), -1);
        end
        wait_idle(6000);

        check("queues_drained", exp_q.size() + exp_addr_q.size() + exp_cmd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
